// File: rtl/median_pkg.sv
// Shared helpers for the windowed median filters: size functions and the
// window-depth legality check used at elaboration.
`define MEDIAN_CHECK_DEPTH(d, lo, hi) if (((d) % 2 == 0) || ((d) < (lo)) || ((d) > (hi))) begin : g_bad_depth $error("median filter: DEPTH=%0d must be odd and within [%0d,%0d]", d, lo, hi); end

package median_pkg;

    localparam int MIN_DEPTH = 3;
    localparam int MAX_DEPTH = 15;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int mid_of(input int depth);
        return depth / 2;
    endfunction

    function automatic int rank_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/median_rank.sv
// Rank of one window entry: count of smaller entries plus equal entries at a
// lower index, so duplicate values still yield a permutation of 0..DEPTH-1.
module median_rank
    import median_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 3,
    parameter int INDEX  = 0,
    parameter int RANK_W = rank_w(DEPTH)
)(
    input  logic [DEPTH*WIDTH-1:0] window,
    output logic [RANK_W-1:0]      rank
);

    logic [WIDTH-1:0] self_val;

    assign self_val = window[INDEX*WIDTH +: WIDTH];

    always_comb begin
        rank = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((window[j*WIDTH +: WIDTH] < self_val) ||
                ((j < INDEX) && (window[j*WIDTH +: WIDTH] == self_val))) begin
                rank = rank + RANK_W'(1);
            end
        end
    end

endmodule

// File: rtl/median_window.sv
// Streaming sliding-window median: shift window, per-entry rank, then select
// the middle-ranked entry. Two cycles from accepted sample to median_valid.
module median_window
    import median_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 3
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic [WIDTH-1:0] median_out,
    output logic             median_valid,
    output logic             window_full
);

    localparam int MID    = mid_of(DEPTH);
    localparam int RANK_W = rank_w(DEPTH);
    localparam int CNT_W  = clog2(DEPTH + 1);

    `MEDIAN_CHECK_DEPTH(DEPTH, MIN_DEPTH, MAX_DEPTH)

    logic [WIDTH-1:0]       win_p0 [DEPTH];
    logic [CNT_W-1:0]       fill_p0;
    logic [CNT_W-1:0]       fill_next;
    logic                   vld_p0;
    logic [DEPTH*WIDTH-1:0] win_flat_p0;
    logic [RANK_W-1:0]      rank_c [DEPTH];
    logic [WIDTH-1:0]       win_p1 [DEPTH];
    logic [RANK_W-1:0]      rank_p1 [DEPTH];
    logic                   vld_p1;
    logic [WIDTH-1:0]       median_sel;

    assign window_full = (fill_p0 == CNT_W'(DEPTH));
    assign fill_next   = window_full ? fill_p0 : fill_p0 + CNT_W'(1);

    // Stage 0: shift window, fill count, warm-up gated valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win_p0[i] <= '0;
            fill_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) win_p0[i] <= '0;
            fill_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (data_in_valid) begin
            win_p0[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) win_p0[i] <= win_p0[i-1];
            fill_p0 <= fill_next;
            vld_p0  <= (fill_next == CNT_W'(DEPTH));
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rank
        assign win_flat_p0[g*WIDTH +: WIDTH] = win_p0[g];

        median_rank #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .INDEX  (g),
            .RANK_W (RANK_W)
        ) u_rank (
            .window (win_flat_p0),
            .rank   (rank_c[g])
        );
    end

    // Stage 1: register ranks alongside a copy of the window
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_p1[i]  <= '0;
                rank_p1[i] <= '0;
            end
            vld_p1 <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_p1[i]  <= '0;
                rank_p1[i] <= '0;
            end
            vld_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                win_p1[i]  <= win_p0[i];
                rank_p1[i] <= rank_c[i];
            end
            vld_p1 <= vld_p0;
        end
    end

    always_comb begin
        median_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rank_p1[i] == RANK_W'(MID)) median_sel = win_p1[i];
        end
    end

    // Stage 2: median output; holds between pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            median_out   <= '0;
            median_valid <= 1'b0;
        end else if (clear) begin
            median_out   <= '0;
            median_valid <= 1'b0;
        end else begin
            if (vld_p1) median_out <= median_sel;
            median_valid <= vld_p1;
        end
    end

endmodule
